// File: rtl/banco_registradores_param_if.sv
// Register bank port bundle: two read ports, write port, scoreboard set.
// master = pipeline side, slave = register bank.
interface banco_registradores_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              busy_a;
    logic              busy_b;
    logic              busy_any;

    modport master (
        output rd_addr_a, rd_addr_b,
        output we, wr_addr, wr_data,
        output sb_set, sb_addr,
        input  rd_data_a, rd_data_b,
        input  busy_a, busy_b, busy_any
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  we, wr_addr, wr_data,
        input  sb_set, sb_addr,
        output rd_data_a, rd_data_b,
        output busy_a, busy_b, busy_any
    );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised register bank: 2 async reads, 1 sync write, busy scoreboard.
// Optional write-to-read bypass enabled by defining BANCO_BYPASS_EN.
module banco_registradores_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    banco_registradores_param_if.slave  bus
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic                busy_any_q;
    logic                busy_any_d;

    logic                wr_ok;
    logic                sb_ok;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic                bz_a;
    logic                bz_b;

    // Register 0 is not addressable for writes when it is hardwired to zero
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    assign wr_ok = bus.we && legal(bus.wr_addr);
    assign sb_ok = bus.sb_set && legal(bus.sb_addr);

    // Set after clear so a newly issued producer wins over write-back
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && bus.wr_addr == ADDR_W'(i)) begin
                regs_d[i] = bus.wr_data;
                sb_d[i]   = 1'b0;
            end
            if (sb_ok && bus.sb_addr == ADDR_W'(i)) begin
                sb_d[i] = 1'b1;
            end
        end
        busy_any_d = |sb_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_q       <= '0;
            busy_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sb_q       <= sb_d;
            busy_any_q <= busy_any_d;
        end
    end

    // Out-of-range addresses match no entry and fall through to zero
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        bz_a = 1'b0;
        bz_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) begin
                rd_a = regs_q[i];
                bz_a = sb_q[i];
            end
            if (bus.rd_addr_b == ADDR_W'(i)) begin
                rd_b = regs_q[i];
                bz_b = sb_q[i];
            end
        end
`ifdef BANCO_BYPASS_EN
        if (wr_ok && bus.wr_addr == bus.rd_addr_a) begin
            rd_a = bus.wr_data;
            bz_a = sb_ok && (bus.sb_addr == bus.rd_addr_a);
        end
        if (wr_ok && bus.wr_addr == bus.rd_addr_b) begin
            rd_b = bus.wr_data;
            bz_b = sb_ok && (bus.sb_addr == bus.rd_addr_b);
        end
`endif
        if (!rst_n) begin
            rd_a = '0;
            rd_b = '0;
            bz_a = 1'b0;
            bz_b = 1'b0;
        end
    end

    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.busy_a    = bz_a;
    assign bus.busy_b    = bz_b;
    assign bus.busy_any  = busy_any_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Scoreboard bench for banco_registradores_param: default build plus a
// NUM_REGS=12 / ZERO_REG=1 instance driven with identical stimulus.
module tb_banco_registradores_param;

`ifdef BANCO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic        any;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    banco_registradores_param_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
    banco_registradores_param_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

    banco_registradores_param #(
        .DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .ZERO_REG(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    banco_registradores_param #(
        .DATA_W(16), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    int n_pass = 0;
    int n_tot  = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model: plain arrays, one set per instance
    int          nregs [2] = '{16, 12};
    bit          zreg  [2] = '{1'b0, 1'b1};
    logic [15:0] mem   [2][16];
    bit          bsy   [2][16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic bit lg(input int k, input logic [3:0] a);
        return (int'(a) < nregs[k]) && !(zreg[k] && a == 4'd0);
    endfunction

    function automatic logic [15:0] m_rd(input int k, input logic [3:0] ra,
        input bit we, input logic [3:0] wa, input logic [15:0] wd);
        if (!lg(k, ra)) return 16'h0;
        if (BYP && we && wa == ra) return wd;
        return mem[k][ra];
    endfunction

    function automatic bit m_bz(input int k, input logic [3:0] ra,
        input bit we, input logic [3:0] wa, input bit sb,
        input logic [3:0] sa);
        if (!lg(k, ra)) return 1'b0;
        if (BYP && we && wa == ra) return sb && sa == ra;
        return bsy[k][ra];
    endfunction

    function automatic bit m_any(input int k);
        bit r = 1'b0;
        for (int i = 0; i < 16; i++) r |= bsy[k][i];
        return r;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                mem[k][i] = 16'h0;
                bsy[k][i] = 1'b0;
            end
    endtask

    task automatic drive(input bit we, input logic [3:0] wa,
        input logic [15:0] wd, input bit sb, input logic [3:0] sa,
        input logic [3:0] ra, input logic [3:0] rb);
        ifa.we = we; ifa.wr_addr = wa; ifa.wr_data = wd;
        ifa.sb_set = sb; ifa.sb_addr = sa;
        ifa.rd_addr_a = ra; ifa.rd_addr_b = rb;
        ifb.we = we; ifb.wr_addr = wa; ifb.wr_data = wd;
        ifb.sb_set = sb; ifb.sb_addr = sa;
        ifb.rd_addr_a = ra; ifb.rd_addr_b = rb;
    endtask

    // One cycle of stimulus; expected reads refer to state before the edge
    task automatic step(input bit we, input logic [3:0] wa,
        input logic [15:0] wd, input bit sb, input logic [3:0] sa,
        input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(we, wa, wd, sb, sa, ra, rb);
        for (int k = 0; k < 2; k++) begin
            e.da  = m_rd(k, ra, we, wa, wd);
            e.db  = m_rd(k, rb, we, wa, wd);
            e.ba  = m_bz(k, ra, we, wa, sb, sa);
            e.bb  = m_bz(k, rb, we, wa, sb, sa);
            e.any = m_any(k);
            if (k == 0) qa.push_back(e);
            else qb.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            if (we && lg(k, wa)) begin
                mem[k][wa] = wd;
                bsy[k][wa] = 1'b0;
            end
            if (sb && lg(k, sa)) bsy[k][sa] = 1'b1;
        end
    endtask

    task automatic cmp(input string tag, input exp_t e,
        input logic [15:0] da, input logic [15:0] db,
        input logic ba, input logic bb, input logic any);
        chk({tag, " rd_data_a"}, 32'(da), 32'(e.da));
        chk({tag, " rd_data_b"}, 32'(db), 32'(e.db));
        chk({tag, " busy_a"}, 32'(ba), 32'(e.ba));
        chk({tag, " busy_b"}, 32'(bb), 32'(e.bb));
        chk({tag, " busy_any"}, 32'(any), 32'(e.any));
    endtask

    // Monitor: outputs are stable by the falling edge of each stimulus cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("dut", e, ifa.rd_data_a, ifa.rd_data_b,
                    ifa.busy_a, ifa.busy_b, ifa.busy_any);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("dut_b", e, ifb.rd_data_a, ifb.rd_data_b,
                    ifb.busy_a, ifb.busy_b, ifb.busy_any);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        m_clear();
        #3;
        chk("rst rd_data_a", 32'(ifa.rd_data_a), 32'h0);
        chk("rst busy_any", 32'(ifa.busy_any), 32'h0);
        chk("rst_b busy_any", 32'(ifb.busy_any), 32'h0);
        #10;
        rst_n = 1'b1;

        // Fill every register with FFFF and mark each busy
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'(i), 16'hFFFF, 1'b1, 4'(i), 4'(i), 4'(i + 1));
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd3);

        // Asynchronous reset between edges, with a write pending
        @(posedge clk);
        #2;
        chk("pre-rst busy_any", 32'(ifa.busy_any), 32'(m_any(0)));
        drive(1'b1, 4'd5, 16'h5555, 1'b1, 4'd5, 4'd5, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("async rst rd_data_a", 32'(ifa.rd_data_a), 32'h0);
        chk("async rst rd_data_b", 32'(ifa.rd_data_b), 32'h0);
        chk("async rst busy_a", 32'(ifa.busy_a), 32'h0);
        chk("async rst busy_any", 32'(ifa.busy_any), 32'h0);
        chk("async rst_b busy_any", 32'(ifb.busy_any), 32'h0);
        chk("async rst_b rd_data_b", 32'(ifb.rd_data_b), 32'h0);
        @(posedge clk);
        #2;
        chk("in rst rd_data_a", 32'(ifa.rd_data_a), 32'h0);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
        m_clear();
        #1;
        rst_n = 1'b1;

        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd3);
        step(1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 4'd3, 4'd3);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd3, 4'd3);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd2, 4'd4);

        step(1'b1, 4'd7, 16'h0BAD, 1'b0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 4'd7, 16'h1234, 1'b0, 4'd0, 4'd7, 4'd7);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd3);

        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd9, 4'd9);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd8);
        step(1'b1, 4'd9, 16'h4321, 1'b0, 4'd0, 4'd9, 4'd9);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd9);
        step(1'b1, 4'd9, 16'h9999, 1'b1, 4'd9, 4'd9, 4'd1);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd9);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd9, 4'd9);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd9);

        step(1'b1, 4'd0, 16'hBEEF, 1'b1, 4'd0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);

        step(1'b1, 4'd13, 16'h7777, 1'b1, 4'd13, 4'd13, 4'd11);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd13, 4'd13);
        step(1'b1, 4'd11, 16'h1111, 1'b0, 4'd0, 4'd11, 4'd13);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd11, 4'd11);

        for (int n = 0; n < 600; n++) begin
            logic [3:0] wa;
            logic [3:0] sa;
            wa = 4'($urandom_range(0, 15));
            sa = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(1'($urandom), wa, 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 sa, ($urandom_range(0, 3) == 0) ? wa : 4'($urandom),
                 4'($urandom));
        end
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard drain", 32'(qa.size() + qb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
Parametrised successor to the CPU's 16x16 register bank, used in the datapath between decode and execute.
- Two asynchronous read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- Per-register busy scoreboard, so the pipeline control unit can detect read-after-write hazards on in-flight results.
- Optional write-to-read bypass.

Parameters:
DATA_W, 16, width of each register and of all data ports
ADDR_W, 4, width of all address ports
NUM_REGS, 16, number of implemented registers (legal range 2..2**ADDR_W)
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and scoreboard sets

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data
rd_data_b  output  DATA_W  read port B data
we  input  1  write enable; 1 = write wr_data to wr_addr at next rising edge
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
sb_set  input  1  1 = mark sb_addr busy at next rising edge (instruction issued with this destination)
sb_addr  input  ADDR_W  scoreboard set address
busy_a  output  1  scoreboard bit of rd_addr_a
busy_b  output  1  scoreboard bit of rd_addr_b
busy_any  output  1  OR of all scoreboard bits (pipeline drain indicator)

Behaviour:
- Reset: rst_n=0 asynchronously clears every register and every scoreboard bit to 0, without waiting for clk.
  - While in reset, rd_data_a/b read 0 and busy_a/b/busy_any read 0.
  - Reset asserted mid-write: the write is lost; the register reads 0.
  - Writes resume at the first rising edge after rst_n returns to 1.
- Read:
  - Purely combinational; rd_data_x = regs[rd_addr_x]; zero latency.
  - Address >= NUM_REGS reads 0, and its busy_x reads 0.
  - With ZERO_REG=1, address 0 always reads 0 and its busy reads 0.
- Write:
  - On the rising edge, if we=1 and wr_addr is legal, regs[wr_addr] <= wr_data.
  - Illegal address (>= NUM_REGS, or 0 with ZERO_REG=1): write silently dropped.
  - The new value is visible on the read ports starting the cycle after the edge.
  - Without the bypass, a same-cycle read of wr_addr returns the old value.
- Scoreboard, one bit per register, updated at the rising edge:
  - we=1 clears bit[wr_addr] (result written back).
  - sb_set=1 sets bit[sb_addr].
  - sb_set and we on the same address in the same cycle: set wins, bit ends at 1 (a new producer has been issued).
  - sb_set on a register already busy: stays 1, no error.
  - we on a register not busy: plain write, bit stays 0.
  - Illegal sb_addr: ignored.
- busy_any: registered OR of the scoreboard bits, updated with them; 0 after reset.
- Both read ports may address the same register, each other, or the write address in any combination; no port arbitration and no stalls inside this block.
- Widths: wr_data is stored unmodified; no sign or zero extension inside the block.

Optional Feature:
Macro BANCO_BYPASS_EN.
- Defined: when we=1 and wr_addr equals rd_addr_x (legal, non-zero-reg address), rd_data_x = wr_data combinationally in that same cycle.
  - In the same case, busy_x reads 0 unless sb_set targets the same address in that cycle.
- Not defined: reads in the write cycle return the stored (old) value and the stored busy bit.
- Either way, the stored state after the edge is identical.

Test Plan:
- Reset with all registers written to 16'hFFFF: drop rst_n to 0 between clock edges -> rd_data_a/b=0 and busy_any=0 immediately; register 5 still reads 0 after rst_n releases.
- Write 16'hA5A5 to r3, then read with rd_addr_a=3 and rd_addr_b=3 on the next cycle -> both ports show 16'hA5A5; r2 and r4 still read 0.
- Read r7 in the same cycle as writing 16'h1234 to r7 (r7 previously 16'h0BAD) -> 16'h0BAD without BANCO_BYPASS_EN, 16'h1234 with it; next cycle 16'h1234 in both builds.
- Scoreboard: sb_set r9 -> busy_a=1 for rd_addr_a=9 and busy_any=1 next cycle; we r9 -> busy_a=0 next cycle; sb_set and we both on r9 in the same cycle -> busy_a stays 1 and r9 holds the written data.
- ZERO_REG=1: write 16'hBEEF to r0 and sb_set r0 -> r0 reads 0 and busy reads 0. ZERO_REG=0: the same stimulus makes r0 read 16'hBEEF.
- NUM_REGS=12, ADDR_W=4: write 16'h7777 to address 13 -> dropped; address 13 reads 0 and its busy reads 0; r11 write/read works normally.
